// File: rtl/uart_csr_bridge_pkg.sv
// rtl/uart_csr_bridge_pkg.sv - shared constants, state encoding and helpers for the UART CSR bridge
//
// Purpose: command byte values, acknowledge byte, CSR address width and the
// bridge FSM state encoding, shared by the interface, top and sub-module.
package uart_csr_bridge_pkg;

  localparam int CSR_AW = 14;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] ACK_BYTE  = 8'hAA;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_WR_DATA,
    ST_WR_STB,
    ST_RD_STB,
    ST_RD_WAIT,
    ST_RD_SEND,
    ST_RD_TXW,
    ST_ACK,
    ST_ACK_TXW
  } state_e;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_WRITE) || (b == CMD_READ);
  endfunction

endpackage

// File: rtl/uart_csr_bridge_if.sv
// rtl/uart_csr_bridge_if.sv - UART transceiver and CSR bus signal bundle for the bridge
//
// Purpose: groups the transceiver handshake (rx/tx) and CSR initiator bus.
// Modports:
//   master - the bridge: drives tx_data/tx_wr, csr_a/csr_we/csr_dw, busy
//   slave  - the environment: drives rx_data/rx_done, tx_done, csr_dr
interface uart_csr_bridge_if;
  import uart_csr_bridge_pkg::*;

  logic [7:0]        rx_data;
  logic              rx_done;
  logic [7:0]        tx_data;
  logic              tx_wr;
  logic              tx_done;
  logic [CSR_AW-1:0] csr_a;
  logic              csr_we;
  logic [7:0]        csr_dw;
  logic [7:0]        csr_dr;
  logic              busy;

  modport master (
    input  rx_data, rx_done, tx_done, csr_dr,
    output tx_data, tx_wr, csr_a, csr_we, csr_dw, busy
  );

  modport slave (
    output rx_data, rx_done, tx_done, csr_dr,
    input  tx_data, tx_wr, csr_a, csr_we, csr_dw, busy
  );

endinterface

// File: rtl/uart_csr_bridge_timeout.sv
// rtl/uart_csr_bridge_timeout.sv - inter-byte gap down-counter with reload and enable
//
// Purpose: counts down while enabled; expired_o rises in the CYCLES-th enabled
// cycle after the last reload. Reload has priority over expiry.
// Ports:
//   clk_i     - clock
//   rst_i     - synchronous active-high reset (loads the counter)
//   reload_i  - reload the counter (one per received byte)
//   en_i      - count enable
//   expired_o - counter reached zero while enabled
module uart_csr_bridge_timeout #(
  parameter int CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic reload_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LOAD = W'(CYCLES - 1);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= LOAD;
    end else if (reload_i) begin
      count_q <= LOAD;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign expired_o = en_i && (count_q == '0);

endmodule

// File: rtl/uart_csr_bridge.sv
// rtl/uart_csr_bridge.sv - CSR bus initiator driven by framed UART host commands
//
// Purpose: parses CMD, LEN, ADDR_H, ADDR_L [, data...] frames from the UART
// receiver and issues CSR write or read bursts; read data is returned through
// the transmitter one byte at a time, waiting for tx_done between bytes.
// Optional feature macro: UART_CSR_BRIDGE_WRITE_ACK_EN (send ACK_BYTE after a
// write burst).
// Ports:
//   sys_clk - system clock
//   sys_rst - synchronous active-high reset
//   bus     - uart_csr_bridge_if.master (rx/tx handshake, CSR bus, busy)
// Parameters:
//   clk_freq         - clock frequency in Hz
//   timeout_ms       - maximum inter-byte gap inside a command
//   csr_read_latency - cycles from csr_a valid to csr_dr valid (1 or 2)
module uart_csr_bridge
  import uart_csr_bridge_pkg::*;
#(
  parameter int clk_freq         = 100000000,
  parameter int timeout_ms       = 10,
  parameter int csr_read_latency = 1
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  uart_csr_bridge_if.master      bus
);

  localparam int TIMEOUT_CYCLES = clk_freq / 1000 * timeout_ms;
  localparam logic [1:0] LAT_LAST = 2'(csr_read_latency - 1);

  state_e            state_q, state_d;
  logic              busy_q;
  logic [7:0]        tx_data_q;
  logic              tx_wr_q;
  logic [CSR_AW-1:0] csr_a_q;
  logic              csr_we_q;
  logic [7:0]        csr_dw_q;
  logic              is_write_q;
  logic [8:0]        remain_q;
  logic [5:0]        addr_h_q;
  logic [1:0]        lat_q;

  logic last;
  logic timeout_en;
  logic expired;
  logic tx_start;

  // Remaining-transfer count of 1 means the current access is the final one.
  assign last = (remain_q == 9'd1);

  assign timeout_en = (state_q == ST_LEN) || (state_q == ST_ADDR_H) ||
                      (state_q == ST_ADDR_L) || (state_q == ST_WR_DATA);

  uart_csr_bridge_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (sys_clk),
    .rst_i     (sys_rst),
    .reload_i  (bus.rx_done),
    .en_i      (timeout_en),
    .expired_o (expired)
  );

  // rx_done is tested before expiry so a byte in the expiry cycle is accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (bus.rx_done && is_cmd(bus.rx_data)) state_d = ST_LEN;
      ST_LEN:     if (bus.rx_done) state_d = ST_ADDR_H;
                  else if (expired) state_d = ST_IDLE;
      ST_ADDR_H:  if (bus.rx_done) state_d = ST_ADDR_L;
                  else if (expired) state_d = ST_IDLE;
      ST_ADDR_L:  if (bus.rx_done) state_d = is_write_q ? ST_WR_DATA : ST_RD_STB;
                  else if (expired) state_d = ST_IDLE;
      ST_WR_DATA: if (bus.rx_done) state_d = ST_WR_STB;
                  else if (expired) state_d = ST_IDLE;
`ifdef UART_CSR_BRIDGE_WRITE_ACK_EN
      ST_WR_STB:  state_d = last ? ST_ACK : ST_WR_DATA;
      ST_ACK:     state_d = ST_ACK_TXW;
      ST_ACK_TXW: if (bus.tx_done) state_d = ST_IDLE;
`else
      ST_WR_STB:  state_d = last ? ST_IDLE : ST_WR_DATA;
`endif
      ST_RD_STB:  state_d = ST_RD_WAIT;
      ST_RD_WAIT: if (lat_q == LAT_LAST) state_d = ST_RD_SEND;
      ST_RD_SEND: state_d = ST_RD_TXW;
      ST_RD_TXW:  if (bus.tx_done) state_d = last ? ST_IDLE : ST_RD_STB;
      default:    state_d = ST_IDLE;
    endcase
  end

`ifdef UART_CSR_BRIDGE_WRITE_ACK_EN
  assign tx_start = (state_d == ST_RD_SEND) || (state_d == ST_ACK);
`else
  assign tx_start = (state_d == ST_RD_SEND);
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_wr_q    <= 1'b0;
      csr_a_q    <= '0;
      csr_we_q   <= 1'b0;
      csr_dw_q   <= 8'h00;
      is_write_q <= 1'b0;
      remain_q   <= 9'd0;
      addr_h_q   <= 6'd0;
      lat_q      <= 2'd0;
    end else begin
      state_q  <= state_d;
      busy_q   <= (state_d != ST_IDLE);
      csr_we_q <= (state_d == ST_WR_STB);
      tx_wr_q  <= tx_start;
      case (state_q)
        ST_IDLE:    if (bus.rx_done) is_write_q <= (bus.rx_data == CMD_WRITE);
        ST_LEN:     if (bus.rx_done) remain_q <= (bus.rx_data == 8'h00) ? 9'd256 : {1'b0, bus.rx_data};
        ST_ADDR_H:  if (bus.rx_done) addr_h_q <= bus.rx_data[5:0];
        ST_ADDR_L:  if (bus.rx_done) csr_a_q <= {addr_h_q, bus.rx_data};
        ST_WR_DATA: if (bus.rx_done) csr_dw_q <= bus.rx_data;
        ST_WR_STB: begin
          // Address advances only between accesses so it holds after the burst.
          if (!last) begin
            csr_a_q  <= csr_a_q + CSR_AW'(1);
            remain_q <= remain_q - 9'd1;
          end
`ifdef UART_CSR_BRIDGE_WRITE_ACK_EN
          else begin
            tx_data_q <= ACK_BYTE;
          end
`endif
        end
        ST_RD_STB:  lat_q <= 2'd0;
        ST_RD_WAIT: begin
          lat_q <= lat_q + 2'd1;
          if (lat_q == LAT_LAST) tx_data_q <= bus.csr_dr;
        end
        ST_RD_TXW: begin
          if (bus.tx_done && !last) begin
            csr_a_q  <= csr_a_q + CSR_AW'(1);
            remain_q <= remain_q - 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.tx_data = tx_data_q;
  assign bus.tx_wr   = tx_wr_q;
  assign bus.csr_a   = csr_a_q;
  assign bus.csr_we  = csr_we_q;
  assign bus.csr_dw  = csr_dw_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_uart_csr_bridge.sv
// tb/tb_uart_csr_bridge.sv - scoreboard testbench for uart_csr_bridge
module tb_uart_csr_bridge;

  localparam int CLK_FREQ   = 100000;
  localparam int TIMEOUT_MS = 1;
  localparam int TO_CYCLES  = CLK_FREQ / 1000 * TIMEOUT_MS;
  localparam int TX_DELAY   = 8;

  typedef struct packed {
    logic [13:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 clk = ~clk;

  uart_csr_bridge_if bus();

  uart_csr_bridge #(
    .clk_freq         (CLK_FREQ),
    .timeout_ms       (TIMEOUT_MS),
    .csr_read_latency (2)
  ) dut (
    .sys_clk (clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int tx_count = 0;
  int tx_busy_cnt = 0;
  wr_t wr_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] slv_stage = 8'h00;

  // Registered slave with two-cycle read latency, data = address low byte.
  always @(posedge clk) begin
    slv_stage  <= bus.csr_a[7:0];
    bus.csr_dr <= slv_stage;
  end

  // Transmitter model: tx_done TX_DELAY cycles after each tx_wr.
  always @(posedge clk) begin
    #1;
    bus.tx_done = 1'b0;
    if (tx_busy_cnt > 0) begin
      tx_busy_cnt--;
      if (tx_busy_cnt == 0) bus.tx_done = 1'b1;
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!sys_rst) begin
      if (bus.csr_we === 1'b1) begin
        n_cmp++;
        if (wr_q.size() == 0) begin
          n_err++;
          $display("FAIL csr_write_unexpected: got a=%h d=%h, required no write", bus.csr_a, bus.csr_dw);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          if ({bus.csr_a, bus.csr_dw} !== {e.addr, e.data}) begin
            n_err++;
            $display("FAIL csr_write: got a=%h d=%h, required a=%h d=%h", bus.csr_a, bus.csr_dw, e.addr, e.data);
          end
        end
      end
      if (bus.tx_wr === 1'b1) begin
        n_cmp++;
        if (tx_busy_cnt != 0) begin
          n_err++;
          $display("FAIL tx_overlap: tx_wr with byte outstanding (%0d cycles left), required none", tx_busy_cnt);
        end
        tx_count++;
        n_cmp++;
        if (tx_q.size() == 0) begin
          n_err++;
          $display("FAIL tx_unexpected: got %h, required no tx", bus.tx_data);
        end else begin
          logic [7:0] eb;
          eb = tx_q.pop_front();
          if (bus.tx_data !== eb) begin
            n_err++;
            $display("FAIL tx_byte: got %h, required %h", bus.tx_data, eb);
          end
        end
        tx_busy_cnt = TX_DELAY;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(posedge clk); #1;
    bus.rx_done = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    @(negedge clk);
    while (bus.busy === 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, required 0", name, bus.busy, k);
    end
    repeat (TX_DELAY + 2) @(negedge clk);
    n_cmp++;
    if (wr_q.size() != 0 || tx_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_leftover: wr=%0d tx=%0d pending, required 0/0", name, wr_q.size(), tx_q.size());
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++; if (bus.tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %h, required 00", bus.tx_data); end
    n_cmp++; if (bus.tx_wr !== 1'b0) begin n_err++; $display("FAIL reset_tx_wr: got %b, required 0", bus.tx_wr); end
    n_cmp++; if (bus.csr_a !== 14'h0) begin n_err++; $display("FAIL reset_csr_a: got %h, required 0000", bus.csr_a); end
    n_cmp++; if (bus.csr_we !== 1'b0) begin n_err++; $display("FAIL reset_csr_we: got %b, required 0", bus.csr_we); end
    n_cmp++; if (bus.csr_dw !== 8'h00) begin n_err++; $display("FAIL reset_csr_dw: got %h, required 00", bus.csr_dw); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
  endtask

  task automatic test_write;
    wr_q.push_back('{addr: 14'h0010, data: 8'h5A});
    wr_q.push_back('{addr: 14'h0011, data: 8'hA5});
`ifdef UART_CSR_BRIDGE_WRITE_ACK_EN
    tx_q.push_back(8'hAA);
`endif
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h00); send_byte(8'h10);
    send_byte(8'h5A); send_byte(8'hA5);
    wait_idle("write", 200);
  endtask

  task automatic test_read_wrap;
    tx_count = 0;
    tx_q.push_back(8'hFF); tx_q.push_back(8'h00); tx_q.push_back(8'h01);
    send_byte(8'h02); send_byte(8'h03); send_byte(8'h3F); send_byte(8'hFF);
    wait_idle("read_wrap", 500);
    n_cmp++;
    if (tx_count != 3) begin n_err++; $display("FAIL read_wrap_count: got %0d, required 3", tx_count); end
    n_cmp++;
    if (bus.csr_a !== 14'h0001) begin n_err++; $display("FAIL read_wrap_addr_hold: got %h, required 0001", bus.csr_a); end
  endtask

  task automatic test_read_256;
    tx_count = 0;
    for (int i = 0; i < 256; i++) tx_q.push_back(8'(i));
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    wait_idle("read_256", 6000);
    n_cmp++;
    if (tx_count != 256) begin n_err++; $display("FAIL read_256_count: got %0d, required 256", tx_count); end
  endtask

  task automatic test_timeout;
    send_byte(8'h01); send_byte(8'h01); send_byte(8'h00);
    repeat (TO_CYCLES - 10) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_err++; $display("FAIL timeout_early: busy=%b, required 1", bus.busy); end
    repeat (15) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL timeout_expire: busy=%b, required 0", bus.busy); end
    wr_q.push_back('{addr: 14'h0020, data: 8'h33});
`ifdef UART_CSR_BRIDGE_WRITE_ACK_EN
    tx_q.push_back(8'hAA);
`endif
    send_byte(8'h01); send_byte(8'h01); send_byte(8'h00); send_byte(8'h20); send_byte(8'h33);
    wait_idle("after_timeout", 200);
  endtask

  task automatic test_badcmd_reset;
    send_byte(8'h7E);
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL bad_cmd_busy: got %b, required 0", bus.busy); end
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h00); send_byte(8'h40);
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_err++; $display("FAIL wr_data_busy: got %b, required 1", bus.busy); end
    @(posedge clk); #1;
    sys_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.tx_data, bus.tx_wr, bus.csr_a, bus.csr_we, bus.csr_dw, bus.busy} !== 33'h0) begin
      n_err++;
      $display("FAIL midreset_outputs: tx_data=%h tx_wr=%b csr_a=%h csr_we=%b csr_dw=%h busy=%b, required all 0",
               bus.tx_data, bus.tx_wr, bus.csr_a, bus.csr_we, bus.csr_dw, bus.busy);
    end
    @(posedge clk); #1;
    sys_rst = 1'b0;
    send_byte(8'h99);
    wait_idle("after_reset", 50);
  endtask

  task automatic test_stray_rx;
    tx_count = 0;
    tx_q.push_back(8'h34); tx_q.push_back(8'h35);
    send_byte(8'h02); send_byte(8'h02); send_byte(8'hD2); send_byte(8'h34);
    for (int b = 0; b < 2; b++) begin
      int k = 0;
      @(negedge clk);
      while (tx_busy_cnt == 0 && k < 100) begin @(negedge clk); k++; end
      n_cmp++;
      if (tx_busy_cnt == 0) begin n_err++; $display("FAIL stray_wait_tx: no tx_wr within %0d cycles, required one", k); end
      @(posedge clk); #1;
      bus.rx_data = (b == 0) ? 8'h02 : 8'h01;
      bus.rx_done = 1'b1;
      @(posedge clk); #1;
      bus.rx_done = 1'b0;
      k = 0;
      while (tx_busy_cnt != 0 && k < 100) begin @(negedge clk); k++; end
    end
    wait_idle("stray", 500);
    n_cmp++;
    if (tx_count != 2) begin n_err++; $display("FAIL stray_count: got %0d, required 2", tx_count); end
  endtask

  initial begin
    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;
    bus.tx_done = 1'b0;
    sys_rst = 1'b1;
    repeat (3) @(posedge clk);
    test_reset();
    #1 sys_rst = 1'b0;
    test_write();
    test_read_wrap();
    test_read_256();
    test_timeout();
    test_badcmd_reset();
    test_stray_rx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_csr_bridge.md
Name: uart_csr_bridge

Overview:
- CSR bus initiator driven by UART host commands; the master-side counterpart of the UART CSR responder.
- Consumes received bytes from a uart_transceiver (rx_data/rx_done) and issues CSR reads/writes in bursts.
- Returns read data through the same transceiver (tx_data/tx_wr/tx_done).
- Gives a host PC debug access to every CSR slave before the CPU runs.

Parameters:
clk_freq, 100000000, system clock frequency in Hz
timeout_ms, 10, maximum inter-byte gap inside a command before abort
csr_read_latency, 1, cycles from csr_a valid to csr_dr valid (1 or 2)

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  synchronous active-high reset
rx_data  in  8  received byte from transceiver
rx_done  in  1  one-cycle strobe: rx_data valid
tx_data  out 8  byte to transmit
tx_wr    out 1  one-cycle strobe: start transmission of tx_data
tx_done  in  1  one-cycle strobe: transmitter finished previous byte
csr_a    out 14 CSR address
csr_we   out 1  CSR write strobe
csr_dw   out 8  CSR write data
csr_dr   in  8  CSR read data from slaves (OR-combined, registered in slaves)
busy     out 1  high whenever state is not IDLE

Behaviour:
- Frame format: CMD, LEN, ADDR_H, ADDR_L, then LEN data bytes (write only).
- CMD 0x01 = write, 0x02 = read; any other CMD byte is discarded and the block stays in IDLE.
- Transfer count N = LEN, except LEN = 0 means N = 256.
- Start address is {ADDR_H[5:0], ADDR_L}; ADDR_H[7:6] are ignored.
- Address increments by 1 after each access and wraps 0x3FFF -> 0x0000.
- States: IDLE, LEN, ADDR_H, ADDR_L, WR_DATA, WR_STB, RD_STB, RD_WAIT, RD_SEND, RD_TXW, ACK, ACK_TXW.
- Write path:
  - WR_DATA captures each data byte on rx_done, then goes to WR_STB.
  - WR_STB asserts csr_we for exactly one cycle with csr_a and csr_dw stable.
  - After the Nth write, go to ACK if the optional feature is enabled, otherwise IDLE.
- Read path:
  - RD_STB drives csr_a.
  - RD_WAIT holds for csr_read_latency cycles, then captures csr_dr.
  - RD_SEND pulses tx_wr for one cycle with the captured byte.
  - RD_TXW waits for tx_done; after the Nth byte go to IDLE, otherwise increment address and return to RD_STB.
- tx_wr never asserts while a byte is outstanding (i.e. between tx_wr and tx_done).
- rx_done arriving in any state other than IDLE/LEN/ADDR_H/ADDR_L/WR_DATA is dropped.
- Timeout:
  - Counter of clk_freq/1000*timeout_ms cycles; reloads on every rx_done.
  - Runs only in LEN, ADDR_H, ADDR_L, WR_DATA.
  - On expiry go to IDLE; writes already performed are not undone.
  - rx_done in the expiry cycle wins: the byte is accepted and the counter reloads.
- Reset values: tx_data=0, tx_wr=0, csr_a=0, csr_we=0, csr_dw=0, busy=0, state IDLE, timeout counter loaded.
- Reset mid-operation aborts immediately. No partial CSR write is issued, since csr_we is registered and cleared by reset.
- csr_a holds its last value outside accesses. csr_we is low outside WR_STB.
- All outputs are registered.

Optional Feature:
- Macro: UART_CSR_BRIDGE_WRITE_ACK_EN.
- Defined: after the last write of a burst, ACK sends byte 0xAA (one tx_wr pulse) and ACK_TXW waits for tx_done, then IDLE.
- Undefined: ACK/ACK_TXW are not built, write bursts return straight to IDLE, and tx_wr never asserts during writes.

Decomposition:
- Shared package holds:
  - command constants CMD_WRITE=8'h01, CMD_READ=8'h02, ACK_BYTE=8'hAA;
  - state encoding enum;
  - CSR address width constant 14.
- One sub-module: uart_csr_bridge_timeout (loadable down-counter with reload/enable inputs and an expired output).
- Everything else stays in the top FSM.

Test Plan:
- Write 01 02 00 10 5A A5 -> csr_we pulses at csr_a=0x0010 (csr_dw=0x5A) and at 0x0011 (csr_dw=0xA5), one cycle each; with ACK_EN, 0xAA is transmitted after the second pulse.
- Read 02 03 3F FF with slave model returning address low byte -> reads at 0x3FFF, 0x0000, 0x0001; tx bytes FF,00,01, each tx_wr only after the previous tx_done.
- LEN=0 read at 0x0000 -> exactly 256 tx_wr pulses, busy falls after the 256th tx_done.
- Send 01 01 00 then go silent for timeout+1 cycles -> busy drops, no csr_we; a following valid frame executes normally.
- Bad CMD 0x7E, then sys_rst asserted during WR_DATA of a valid frame -> no CSR activity, all outputs at reset values on the next cycle.
- Stray rx_done pulses during a read burst's RD_TXW -> ignored; the read sequence and tx byte count are unchanged.
